// File: rtl/uart_receiver.sv
// uart_receiver: oversampled asynchronous serial receiver feeding a write-only FIFO.
//
// Frames are a low start bit, 5..8 data bits (LSB first), an optional parity or
// verbatim 9th bit, then one or two stop bits. All timing is counted in brgen
// ticks (OVERSAMPLE ticks per bit). Frame format is latched when START is entered.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   brgen               one-clk pulse at OVERSAMPLE x baud rate
//   enable              receiver enable; low forces IDLE and drops any partial frame
//   in                  serial line (idle high), synchronized internally
//   size, parity, stop2 frame format: 5..8 data bits, none/even/odd/9th bit, 1 or 2 stops
//   full                downstream FIFO full; a completing frame is dropped when set
//   data                last written word, unused upper bits zero
//   data_write          one-clk FIFO write strobe
//   parity_error        parity flag of the last written frame
//   framing_error       stop-bit flag of the last written frame
//   overflow            one-clk pulse when a completed frame is dropped
//   busy                high whenever the receiver is not idle
//
// Build option: define RX_MAJORITY_VOTE_EN to take every sample as the 2-of-3
// majority of rx around the nominal sample point.

module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brgen,
    input  logic       enable,
    input  logic       in,
    input  logic [1:0] size,
    input  logic [1:0] parity,
    input  logic       stop2,
    input  logic       full,
    output logic [8:0] data,
    output logic       data_write,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntBitLast = CntW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
    // The vote window M-1..M+1 closes one tick after the nominal mid-bit, so the
    // start decision (and the counter clear) moves one tick later; every later
    // decision at CntBitLast then lands on M+1 of its own bit.
    localparam logic [CntW-1:0] CntStartMid = CntW'(OVERSAMPLE / 2);
`else
    localparam logic [CntW-1:0] CntStartMid = CntW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [8:0]      shift_q, shift_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      par_q, par_d;
    logic            stop2_q, stop2_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic [8:0]      data_q, data_d;
    logic            pe_out_q, pe_out_d;
    logic            fe_out_q, fe_out_d;
    logic            write_q, write_d;
    logic            ovf_q, ovf_d;
    logic            rx_meta_q, rx_q;

    logic            sample;
    logic            at_end;
    logic            done;
    logic [CntW-1:0] cnt_end;
    logic [2:0]      last_idx;
    logic            data_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= in;
            rx_q      <= rx_meta_q;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;  // rx on the previous two brgen ticks

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else if (brgen) begin
            hist_q <= {hist_q[0], rx_q};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_q) | (hist_q[0] & rx_q);
`else
    assign sample = rx_q;
`endif

    assign cnt_end  = (state_q == StStart) ? CntStartMid : CntBitLast;
    assign at_end   = (cnt_q == cnt_end);
    assign last_idx = {1'b0, size_q} + 3'd4;
    // Bits above the frame size are cleared at start, so they do not disturb parity.
    assign data_par = ^shift_q[7:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        size_d   = size_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        done     = 1'b0;
        data_d   = data_q;
        pe_out_d = pe_out_q;
        fe_out_d = fe_out_q;
        write_d  = 1'b0;
        ovf_d    = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (brgen) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (!rx_q) begin
                        state_d = StStart;
                        idx_d   = '0;
                        shift_d = '0;
                        size_d  = size;
                        par_d   = parity;
                        stop2_d = stop2;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                StStart: begin
                    if (at_end) begin
                        state_d = sample ? StIdle : StData;
                    end
                end
                StData: begin
                    if (at_end) begin
                        shift_d[idx_q] = sample;
                        if (idx_q == last_idx) begin
                            idx_d   = '0;
                            state_d = (par_q != 2'b00) ? StParity : StStop1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (at_end) begin
                        unique case (par_q)
                            2'b01:   perr_d = data_par ^ sample;
                            2'b10:   perr_d = ~(data_par ^ sample);
                            2'b11:   shift_d[8] = sample;
                            default: perr_d = 1'b0;
                        endcase
                        state_d = StStop1;
                    end
                end
                StStop1: begin
                    if (at_end) begin
                        if (!sample) ferr_d = 1'b1;
                        if (stop2_q) begin
                            state_d = StStop2;
                        end else begin
                            state_d = StIdle;
                            done    = 1'b1;
                        end
                    end
                end
                StStop2: begin
                    if (at_end) begin
                        if (!sample) ferr_d = 1'b1;
                        state_d = StIdle;
                        done    = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (done) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                write_d  = 1'b1;
                data_d   = shift_d;
                pe_out_d = perr_d;
                fe_out_d = ferr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            size_q   <= '0;
            par_q    <= '0;
            stop2_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            data_q   <= '0;
            pe_out_q <= 1'b0;
            fe_out_q <= 1'b0;
            write_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            size_q   <= size_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            data_q   <= data_d;
            pe_out_q <= pe_out_d;
            fe_out_q <= fe_out_d;
            write_q  <= write_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data          = data_q;
    assign data_write    = write_q;
    assign parity_error  = pe_out_q;
    assign framing_error = fe_out_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, brgen pulses per bit period; SHALL be an even value of 8 or more.
REQ-002 Port: clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: brgen  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-005 Port: enable  input  1  receiver enable.
REQ-006 Port: in  input  1  serial line; idle is high.
REQ-007 Port: size  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 Port: parity  input  2  00=none, 01=even, 10=odd, 11=9th bit received verbatim.
REQ-009 Port: stop2  input  1  1 = two stop bits are expected.
REQ-010 Port: full  input  1  downstream FIFO is full.
REQ-011 Port: data  output  9  received word; unused upper bits SHALL be 0.
REQ-012 Port: data_write  output  1  one-clk write strobe to the FIFO.
REQ-013 Port: parity_error  output  1  parity error flag for the last completed frame.
REQ-014 Port: framing_error  output  1  framing error flag for the last completed frame.
REQ-015 Port: overflow  output  1  one-clk pulse when a frame is dropped because full=1.
REQ-016 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The in signal SHALL pass through a 2-flop synchronizer (reset value 1); all sampling SHALL use the synchronized value rx.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP1 and STOP2; a tick counter (0..OVERSAMPLE-1) and a bit index (0..7) SHALL advance only on brgen.
REQ-019 IDLE: when enable=1, brgen=1 and rx=0, the FSM SHALL move to START with the counter cleared.
REQ-020 START: at counter OVERSAMPLE/2-1 (mid-bit), rx=1 SHALL be treated as a false start and return the FSM to IDLE; rx=0 SHALL clear the counter and move the FSM to DATA.
REQ-021 DATA, PARITY, STOP1 and STOP2 SHALL each sample rx once, at counter OVERSAMPLE-1, which is one full bit period after the previous sample.
REQ-022 DATA: data bits SHALL be received LSB first into bits 0..size+4; after the last data bit the FSM SHALL go to PARITY if parity!=00, otherwise to STOP1.
REQ-023 PARITY: for even parity, an error SHALL be flagged if the data bits plus the parity bit hold an odd count of ones; for odd parity, an error SHALL be flagged if that count is even; for parity=11, the sampled bit SHALL be stored in data[8] and parity_error SHALL be 0.
REQ-024 STOP1: if the sampled stop bit is 0, framing_error SHALL be set; if stop2=1 the FSM SHALL go to STOP2, otherwise the frame SHALL complete.
REQ-025 STOP2: if the sampled stop bit is 0, framing_error SHALL be set; the frame SHALL then complete.
REQ-026 Frame completion, with full=0: on the clk after the final mid-bit sample, data_write SHALL be 1 for one cycle, and data, parity_error and framing_error SHALL update together and hold until the next completion.
REQ-027 Frame completion, with full=1: data_write SHALL stay 0, overflow SHALL pulse for one cycle, and data and the flags SHALL be left unchanged.
REQ-028 Frames with errors SHALL still be written.
REQ-029 The FSM SHALL return to IDLE at the final stop sample (mid-bit), so a start edge in the second half of the stop bit is accepted.
REQ-030 enable=0 SHALL force IDLE on the next clk and discard any partial frame, with no data_write and no flag update.
REQ-031 Configuration inputs (size, parity, stop2) SHALL be latched when START is entered; later changes SHALL not affect the frame in progress.

Reset
REQ-032 While reset=1, the next clk SHALL set: state to IDLE, counters to 0, synchronizer to 1, data to 0, and all 1-bit outputs to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no data_write.

Configuration
REQ-034 With RX_MAJORITY_VOTE_EN defined, every sample SHALL be the 2-of-3 majority of rx at counter M-1, M and M+1, where M is the nominal sample count; a start is confirmed only if the majority is 0.
REQ-035 With RX_MAJORITY_VOTE_EN undefined, every sample SHALL be the single value of rx at counter M.

Verification
REQ-036 8N1 input 0xA5, full=0 -> one data_write with data=0x0A5 and both error flags 0.
REQ-037 5E2 (even parity, two stop bits) input 0x13, parity bit 0 -> data=0x013 and parity_error=1; with parity bit 1 -> parity_error=0.
REQ-038 8N1 input 0x3C with the stop bit held low -> data=0x03C, framing_error=1, and data_write still strobes.
REQ-039 A 0.3-bit low glitch on an idle line -> return to IDLE with no data_write; two back-to-back frames 0x55 and 0xAA -> two writes, in order.
REQ-040 full=1 at completion of 0x7E -> overflow pulses once and data holds its previous value; reset asserted mid-DATA -> IDLE, no write.
